// File: rtl/id_stage_if.sv
// id_stage_if: bundles the ID stage's pipeline-facing signals.
//   IF/ID side  : if_id_instruction, if_id_pc_next
//   write-back  : wb_reg_write, wb_rd, wb_data
//   EX/MEM      : ex_mem_reg_write, ex_mem_mem_read, ex_mem_dest, ex_mem_alu_result
//   fetch ctrl  : jump_taken, branch_taken, pc_jump, pc_branch, flush_if, stall
//   ID/EX       : id_ex_* registered control, operands and indices
// Modports: slave = the decode stage itself, master = the surrounding pipeline.
interface id_stage_if;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_next;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic [4:0]  ex_mem_dest;
  logic [31:0] ex_mem_alu_result;
  logic        jump_taken;
  logic        branch_taken;
  logic [31:0] pc_jump;
  logic [31:0] pc_branch;
  logic        flush_if;
  logic        stall;
  logic        id_ex_reg_write;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_mem_to_reg;
  logic        id_ex_alu_src;
  logic [3:0]  id_ex_alu_op;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_dest;

  modport slave (
    input  if_id_instruction, if_id_pc_next,
    input  wb_reg_write, wb_rd, wb_data,
    input  ex_mem_reg_write, ex_mem_mem_read, ex_mem_dest, ex_mem_alu_result,
    output jump_taken, branch_taken, pc_jump, pc_branch, flush_if, stall,
    output id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
    output id_ex_alu_src, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    output id_ex_rs, id_ex_rt, id_ex_dest
  );

  modport master (
    output if_id_instruction, if_id_pc_next,
    output wb_reg_write, wb_rd, wb_data,
    output ex_mem_reg_write, ex_mem_mem_read, ex_mem_dest, ex_mem_alu_result,
    input  jump_taken, branch_taken, pc_jump, pc_branch, flush_if, stall,
    input  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
    input  id_ex_alu_src, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    input  id_ex_rs, id_ex_rt, id_ex_dest
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction decode for the five-stage MIPS pipeline.
// Owns the 32x32 register file (combinational read, r0 hardwired to 0),
// decodes the IF/ID instruction, detects load-use / branch hazards, resolves
// beq/bne/j in this stage and registers decoded control and operands into
// the ID/EX pipeline register.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous active-low reset (clears ID/EX only)
//   bus   - id_stage_if.slave: IF/ID, write-back, EX/MEM inputs;
//           redirect/flush/stall and ID/EX outputs
// Configuration macro: ID_WB_BYPASS_EN
//   defined   - same-cycle write-back is bypassed to the read ports
//   undefined - a read of the register being written back stalls one cycle
module id_stage (
  input  logic      clk,
  input  logic      rst_n,
  id_stage_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  assign op    = bus.if_id_instruction[31:26];
  assign rs    = bus.if_id_instruction[25:21];
  assign rt    = bus.if_id_instruction[20:16];
  assign rd    = bus.if_id_instruction[15:11];
  assign funct = bus.if_id_instruction[5:0];
  assign imm   = bus.if_id_instruction[15:0];

  // Register file
  logic [31:0] rf_mem [32];

  always_ff @(posedge clk) begin
    if (bus.wb_reg_write && bus.wb_rd != 5'd0)
      rf_mem[bus.wb_rd] <= bus.wb_data;
  end

  logic wb_hit_rs, wb_hit_rt;
  assign wb_hit_rs = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs);
  assign wb_hit_rt = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rt);

  logic [31:0] rs_val, rt_val;
  always_comb begin
    rs_val = rf_mem[rs];
    rt_val = rf_mem[rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_hit_rs) rs_val = bus.wb_data;
    if (wb_hit_rt) rt_val = bus.wb_data;
`endif
    if (rs == 5'd0) rs_val = 32'd0;
    if (rt == 5'd0) rt_val = 32'd0;
  end

  // Decode; anything not recognised leaves every control bit at 0 (NOP).
  logic       d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg, d_alu_src, d_zext;
  logic [3:0] d_alu_op;
  logic [4:0] d_dest;
  logic       is_beq, is_bne, is_j, uses_rt;

  always_comb begin
    d_reg_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_src    = 1'b0;
    d_zext       = 1'b0;
    d_alu_op     = ALU_ADD;
    d_dest       = 5'd0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_j         = 1'b0;
    uses_rt      = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        d_dest  = rd;
        d_reg_write = 1'b1;
        case (funct)
          6'h20:   d_alu_op = ALU_ADD;
          6'h22:   d_alu_op = ALU_SUB;
          6'h24:   d_alu_op = ALU_AND;
          6'h25:   d_alu_op = ALU_OR;
          6'h2A:   d_alu_op = ALU_SLT;
          default: d_reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin d_reg_write = 1'b1; d_alu_src = 1'b1; d_dest = rt; d_alu_op = ALU_ADD; end
      OP_SLTI: begin d_reg_write = 1'b1; d_alu_src = 1'b1; d_dest = rt; d_alu_op = ALU_SLT; end
      OP_ANDI: begin d_reg_write = 1'b1; d_alu_src = 1'b1; d_dest = rt; d_alu_op = ALU_AND; d_zext = 1'b1; end
      OP_ORI:  begin d_reg_write = 1'b1; d_alu_src = 1'b1; d_dest = rt; d_alu_op = ALU_OR;  d_zext = 1'b1; end
      OP_LW: begin
        d_reg_write  = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_alu_src    = 1'b1;
        d_dest       = rt;
      end
      OP_SW: begin d_mem_write = 1'b1; d_alu_src = 1'b1; uses_rt = 1'b1; end
      OP_BEQ: begin is_beq = 1'b1; uses_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; uses_rt = 1'b1; end
      OP_J:   is_j = 1'b1;
      default: ;
    endcase
    // NOP funct codes must not leave a stale destination behind
    if (!d_reg_write) d_dest = 5'd0;
  end

  logic [31:0] imm_ext;
  assign imm_ext = d_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

  // ID/EX register state
  logic        id_ex_reg_write_reg, id_ex_mem_read_reg, id_ex_mem_write_reg;
  logic        id_ex_mem_to_reg_reg, id_ex_alu_src_reg;
  logic [3:0]  id_ex_alu_op_reg;
  logic [31:0] id_ex_rs_data_reg, id_ex_rt_data_reg, id_ex_imm_reg;
  logic [4:0]  id_ex_rs_reg, id_ex_rt_reg, id_ex_dest_reg;

  // Hazard detection
  logic is_branch, rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic load_use, br_dep_ex, br_dep_load, wb_conflict, stall_int;
  assign is_branch   = is_beq | is_bne;
  assign rs_hit_ex   = (id_ex_dest_reg != 5'd0) && (id_ex_dest_reg == rs);
  assign rt_hit_ex   = (id_ex_dest_reg != 5'd0) && (id_ex_dest_reg == rt);
  assign rs_hit_mem  = (bus.ex_mem_dest != 5'd0) && (bus.ex_mem_dest == rs);
  assign rt_hit_mem  = (bus.ex_mem_dest != 5'd0) && (bus.ex_mem_dest == rt);
  assign load_use    = id_ex_mem_read_reg && (rs_hit_ex || (uses_rt && rt_hit_ex));
  // A branch needs its operands now, so any producer still in EX blocks it,
  // as does a load in MEM whose data is not yet available.
  assign br_dep_ex   = is_branch && id_ex_reg_write_reg && (rs_hit_ex || rt_hit_ex);
  assign br_dep_load = is_branch && bus.ex_mem_mem_read && (rs_hit_mem || rt_hit_mem);
`ifdef ID_WB_BYPASS_EN
  assign wb_conflict = 1'b0;
`else
  assign wb_conflict = wb_hit_rs || (uses_rt && wb_hit_rt);
`endif
  assign stall_int = load_use | br_dep_ex | br_dep_load | wb_conflict;

  // Branch resolution with EX/MEM ALU-result forwarding
  logic        fwd_rs, fwd_rt, ops_equal;
  logic [31:0] cmp_rs, cmp_rt;
  assign fwd_rs    = bus.ex_mem_reg_write && !bus.ex_mem_mem_read && rs_hit_mem;
  assign fwd_rt    = bus.ex_mem_reg_write && !bus.ex_mem_mem_read && rt_hit_mem;
  assign cmp_rs    = fwd_rs ? bus.ex_mem_alu_result : rs_val;
  assign cmp_rt    = fwd_rt ? bus.ex_mem_alu_result : rt_val;
  assign ops_equal = (cmp_rs == cmp_rt);

  assign bus.stall        = stall_int;
  assign bus.jump_taken   = is_j && !stall_int;
  assign bus.branch_taken = ((is_beq && ops_equal) || (is_bne && !ops_equal)) && !stall_int;
  assign bus.flush_if     = bus.jump_taken | bus.branch_taken;
  assign bus.pc_jump      = {bus.if_id_pc_next[31:28], bus.if_id_instruction[25:0], 2'b00};
  assign bus.pc_branch    = bus.if_id_pc_next + {{14{imm[15]}}, imm, 2'b00};

  // j/beq/bne decode with all control at 0, so they enter EX as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || stall_int) begin
      id_ex_reg_write_reg  <= 1'b0;
      id_ex_mem_read_reg   <= 1'b0;
      id_ex_mem_write_reg  <= 1'b0;
      id_ex_mem_to_reg_reg <= 1'b0;
      id_ex_alu_src_reg    <= 1'b0;
      id_ex_alu_op_reg     <= 4'd0;
      id_ex_rs_data_reg    <= 32'd0;
      id_ex_rt_data_reg    <= 32'd0;
      id_ex_imm_reg        <= 32'd0;
      id_ex_rs_reg         <= 5'd0;
      id_ex_rt_reg         <= 5'd0;
      id_ex_dest_reg       <= 5'd0;
    end else begin
      id_ex_reg_write_reg  <= d_reg_write;
      id_ex_mem_read_reg   <= d_mem_read;
      id_ex_mem_write_reg  <= d_mem_write;
      id_ex_mem_to_reg_reg <= d_mem_to_reg;
      id_ex_alu_src_reg    <= d_alu_src;
      id_ex_alu_op_reg     <= d_alu_op;
      id_ex_rs_data_reg    <= rs_val;
      id_ex_rt_data_reg    <= rt_val;
      id_ex_imm_reg        <= imm_ext;
      id_ex_rs_reg         <= rs;
      id_ex_rt_reg         <= rt;
      id_ex_dest_reg       <= d_dest;
    end
  end

  assign bus.id_ex_reg_write  = id_ex_reg_write_reg;
  assign bus.id_ex_mem_read   = id_ex_mem_read_reg;
  assign bus.id_ex_mem_write  = id_ex_mem_write_reg;
  assign bus.id_ex_mem_to_reg = id_ex_mem_to_reg_reg;
  assign bus.id_ex_alu_src    = id_ex_alu_src_reg;
  assign bus.id_ex_alu_op     = id_ex_alu_op_reg;
  assign bus.id_ex_rs_data    = id_ex_rs_data_reg;
  assign bus.id_ex_rt_data    = id_ex_rt_data_reg;
  assign bus.id_ex_imm        = id_ex_imm_reg;
  assign bus.id_ex_rs         = id_ex_rs_reg;
  assign bus.id_ex_rt         = id_ex_rt_reg;
  assign bus.id_ex_dest       = id_ex_dest_reg;
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage pipelined MIPS core. It consumes the IF/ID register (`if_id_instruction`, `if_id_pc_next`) and owns the 32×32 register file. It detects hazards, resolves branches and jumps, and drives the redirect, flush and stall signals back to the fetch stage. It registers decoded operands and control into the ID/EX pipeline register for the execute stage.

## Interface
- Parameters: none.
- `clk` input 1: core clock, all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `if_id_instruction` input 32: instruction held in the IF/ID register.
- `if_id_pc_next` input 32: PC+4 of that instruction.
- `wb_reg_write` input 1: write-back enable.
- `wb_rd` input 5: write-back destination register.
- `wb_data` input 32: write-back data.
- `ex_mem_reg_write` input 1: EX/MEM instruction writes a register.
- `ex_mem_mem_read` input 1: EX/MEM instruction is a load.
- `ex_mem_dest` input 5: EX/MEM destination register.
- `ex_mem_alu_result` input 32: EX/MEM ALU result.
- `jump_taken` output 1: redirect fetch to `pc_jump`.
- `branch_taken` output 1: redirect fetch to `pc_branch`.
- `pc_jump` output 32: `{if_id_pc_next[31:28], instr[25:0], 2'b00}`.
- `pc_branch` output 32: `if_id_pc_next + (sign_ext(instr[15:0]) << 2)`, modulo 2^32.
- `flush_if` output 1: zero the IF/ID register.
- `stall` output 1: hold the PC and the IF/ID register.
- `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write`, `id_ex_mem_to_reg`, `id_ex_alu_src` output 1 each: registered control.
- `id_ex_alu_op` output 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- `id_ex_rs_data`, `id_ex_rt_data`, `id_ex_imm` output 32 each: registered operands and extended immediate.
- `id_ex_rs`, `id_ex_rt`, `id_ex_dest` output 5 each: registered register indices.

## Operation
- **Decode.** Field `op = instr[31:26]`. The ALU source is `alu_src = 1` for every I-type operation.
  - R-type (op 0), by funct:
    - 0x20 → ADD
    - 0x22 → SUB
    - 0x24 → AND
    - 0x25 → OR
    - 0x2A → SLT
    - Any other funct, including the all-zero flushed word, is a NOP.
  - addi (0x08) → ADD, sign-extended immediate.
  - slti (0x0A) → SLT, sign-extended immediate.
  - andi (0x0C) → AND, zero-extended immediate.
  - ori (0x0D) → OR, zero-extended immediate.
  - lw (0x23) → ADD, with `mem_read` and `mem_to_reg` set.
  - sw (0x2B) → ADD, with `mem_write` set.
  - beq (0x04), bne (0x05), j (0x02): handled in ID.
  - Every other opcode is a NOP.
- **Destination.** `dest = rd` for R-type, `rt` for I-type writers. `reg_write = 1` only for ALU operations and lw.
- **NOP.** A NOP drives all control bits to 0.
- **Register file.** Written at the rising edge when `wb_reg_write && wb_rd != 0`. `r0` always reads 0. Reads are combinational.
- **Branch compare.** Operands are taken from `ex_mem_alu_result` when `ex_mem_reg_write && !ex_mem_mem_read && ex_mem_dest != 0 && ex_mem_dest == src`; otherwise from the register file.
- **Stall.** `stall` is asserted when any of the following holds:
  - Load-use: `id_ex_mem_read && id_ex_dest != 0` and `id_ex_dest` matches `rs`, or matches `rt` for an instruction that uses `rt` (R-type, beq, bne, sw).
  - A beq/bne source matches a non-zero `id_ex_dest` with `id_ex_reg_write` set.
  - A beq/bne source matches a non-zero `ex_mem_dest` with `ex_mem_mem_read` set.
- **Redirect.**
  - `jump_taken = (op == j) && !stall`.
  - `branch_taken = (beq && eq || bne && !eq) && !stall`.
  - `flush_if = jump_taken | branch_taken`. There is no delay slot.
  - `stall` forces `jump_taken`, `branch_taken` and `flush_if` to 0.
- **ID/EX register.**
  - On `stall`: loads a bubble (all control 0). Data and index fields are don't-care.
  - Otherwise: loads the decoded values.
  - j, beq and bne load as a bubble.

## Timing
- On reset assertion, every ID/EX output clears to 0 immediately. The register file is not reset.
- After reset, with `if_id_instruction = 0`, all combinational outputs are 0.
- Decode-to-ID/EX latency is one cycle.
- Redirect is combinational and takes effect at the fetch stage's next edge, together with `flush_if`.
- A load-use hazard costs one bubble. A branch dependent on a load in EX costs two bubbles.
- When a write-back and a read of the same register occur in the same cycle, the behaviour is set by the configuration below.
- Reset asserted mid-stall drops `stall`, because the ID/EX state clears.

## Configuration
- `ID_WB_BYPASS_EN` defined: a read port whose index equals a non-zero `wb_rd` with `wb_reg_write` set returns `wb_data` in the same cycle (write-first).
- Undefined: no bypass. `stall` is additionally asserted when `wb_reg_write && wb_rd != 0` and `wb_rd` matches `rs` or a used `rt`. This costs one extra bubble.

## Test plan
- **addi then add.** `wb` writes r1=5. Then `add r3,r1,r1` → next cycle `id_ex_rs_data = 5`, `id_ex_alu_op = 0`, `id_ex_dest = 3`, `id_ex_reg_write = 1`.
- **Load-use.** ID/EX holds `lw r2`. ID holds `add r4,r2,r0` → `stall = 1` for one cycle and a bubble is loaded. The add issues on the following cycle.
- **beq taken.** r5 = r6 = 7 and `if_id_pc_next = 0x104`. `beq r5,r6,+3` → `branch_taken = 1`, `pc_branch = 0x110`, `flush_if = 1`.
- **Jump.** `if_id_pc_next = 0x00000008`, `j 0x40` → `pc_jump = 0x100`, `jump_taken = 1`, `flush_if = 1`.
- **Branch forwarding.** EX/MEM has r7 = 9 (ALU, not load) while the register file holds r7 = 0. `bne r7,r0` → taken without stall.
- **Configuration check.** Same-cycle WB of r8 = 0xA and a read of r8 → with `ID_WB_BYPASS_EN`, `id_ex_rs_data = 0xA` and no stall. Without it, one stall cycle and then 0xA.
